xbus_arbiter: RTL and testbench
===============================

// Module: xbus_arbiter
// PURPOSE
//  Shares the controller's decoded data bus (memory, register file, trap and
//  register ports) between two masters: m0 is the controller core, m1 is the
//  host/debug/DMA port.
//  Round-robin arbitration, with an optional lock so m0 can run atomic
//  read-modify-write sequences.
//  Issues one single-cycle bus_sel transfer per grant, waits RD_LAT cycles for
//  read data, then returns an ack.
//  Sits in front of the address decoder; bus_addr/bus_sel feed it directly.
// PARAMETERS
//  ADDR_W  32  address width of masters and bus
//  DATA_W  32  data width
//  RD_LAT  1   cycles from the bus_sel cycle to bus_rdata valid; legal 1..15
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  m0_req     in   1       m0 transfer request; held with addr/we/wdata stable until m0_ack
//  m0_lock    in   1       m0 keeps ownership while it also requests
//  m0_addr    in   ADDR_W  m0 address
//  m0_we      in   1       m0 write (1) / read (0)
//  m0_wdata   in   DATA_W  m0 write data
//  m0_ack     out  1       one-cycle completion pulse to m0
//  m0_rdata   out  DATA_W  m0 read data, valid while m0_ack=1
//  m1_req, m1_addr, m1_we, m1_wdata, m1_ack, m1_rdata: same as m0 (no lock)
//  bus_sel    out  1       transfer strobe to decoder, high exactly one cycle/transfer
//  bus_addr   out  ADDR_W  registered transfer address
//  bus_we     out  1       registered write enable
//  bus_wdata  out  DATA_W  registered write data
//  bus_rdata  in   DATA_W  decoder read mux output
//  owner      out  1       master of current/last transfer (0=m0, 1=m1)
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs and internal registers go to 0, except owner, which
//   resets to 1 so m0 wins first. State goes to IDLE and the wait counter to 0.
//  FSM: IDLE -> ISSUE -> (WAIT if read) -> DONE -> IDLE.
//  IDLE, some req high: pick a winner, latch its addr/we/wdata into bus_*,
//   set owner, go to ISSUE.
//   Winner rules: if only one master requests, it wins.
//   If both request: m0 wins when m0_lock=1 and owner=0; otherwise the master
//   that is not owner wins.
//   If m0_lock=1 but m0_req=0, normal arbitration applies.
//  ISSUE: bus_sel=1 for this cycle only. Write -> DONE. Read -> WAIT, with the
//   counter loaded to RD_LAT-1.
//  WAIT: lasts exactly RD_LAT cycles (counter decrements to 0). bus_rdata is
//   captured into the owner's rdata register at the clock edge ending the last
//   WAIT cycle. Then -> DONE.
//  DONE: owner's ack=1 for one cycle; the other ack stays 0. -> IDLE.
//  Latency, from the IDLE cycle that samples req: write ack in cycle +2,
//   read ack in cycle +2+RD_LAT.
//   Back-to-back: a master that reasserts req the cycle after ack is sampled
//   in that IDLE cycle.
//  bus_sel is 0 in IDLE, WAIT and DONE. bus_addr/we/wdata hold their value
//   until the next grant.
//  rdata registers hold their value until the next read by the same master.
//   Writes leave rdata unchanged.
//  Req dropped before ack is a protocol violation. The transfer still
//   completes and ack still pulses.
//  Req inputs are ignored outside IDLE; no queuing.
//  Reset mid-transfer (any state): the in-flight transfer is abandoned with no
//   ack and no further bus_sel. Reset values apply the next cycle.
// TESTING
//  1 m0 write addr 0x10 data 0xDEADBEEF from idle -> bus_sel=1 only in cycle
//    +1 (we=1, addr/wdata match); m0_ack in cycle +2; m1_ack never.
//  2 m1 read addr 0x20, RD_LAT=1, bus model returns 0x12345678 one cycle after
//    sel -> m1_ack in cycle +3; m1_rdata=0x12345678; owner=1.
//  3 Both req held continuously after reset, lock=0 -> grant order
//    m0,m1,m0,m1 over 4 transfers; never two bus_sel in adjacent cycles.
//  4 Both req held, m0_lock=1 -> m0 wins 3 consecutive transfers; drop lock ->
//    next grant is m1.
//  5 rst pulsed during WAIT of an m1 read -> next cycle busy=0, bus_sel=0,
//    owner=1; no m1_ack follows.
//  6 RD_LAT=4 build, m0 read -> m0_ack in cycle +6; data captured from
//    bus_rdata valid 4 cycles after sel.

Source files
------------

// File: rtl/xbus_arbiter.sv
// xbus_arbiter
//   Shares the decoded data bus between two masters: m0 (controller core) and
//   m1 (host/debug/DMA port). Round-robin arbitration with an m0 lock for
//   atomic read-modify-write sequences. Each grant issues one single-cycle
//   bus_sel transfer, waits RD_LAT cycles for read data on reads, then pulses
//   the owner's ack for one cycle.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   m0_req/lock/addr/we/wdata    m0 request side (held stable until m0_ack)
//   m0_ack, m0_rdata             m0 completion pulse and read data
//   m1_req/addr/we/wdata         m1 request side (no lock)
//   m1_ack, m1_rdata             m1 completion pulse and read data
//   bus_sel                      one-cycle transfer strobe to the decoder
//   bus_addr/we/wdata            registered transfer fields
//   bus_rdata                    decoder read mux output
//   owner                        master of current/last transfer (0=m0, 1=m1)
//   busy                         high whenever the FSM is not idle
module xbus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The wait counter counts down from RD_LAT-1 so WAIT lasts RD_LAT cycles.
  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       grant;
  logic       grant_m1;
  logic       capture;

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Winner selection: a lone requester wins; with both requesting, a locked
  // m0 that already owns the bus keeps it, otherwise the non-owner wins.
  // Next-state logic follows the IDLE -> ISSUE -> (WAIT) -> DONE loop.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    grant    = 1'b0;
    capture  = 1'b0;
    grant_m1 = m1_req && (!m0_req || (!owner && !m0_lock));
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_we) begin
          state_n = DONE;
        end else begin
          state_n = WAIT;
          cnt_n   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Transfer fields and owner are latched at grant; read data is captured
  // into the owner's register at the edge that ends the last WAIT cycle.
  // owner resets to 1 so m0 wins the first contested arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b1;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      if (grant) begin
        owner     <= grant_m1;
        bus_addr  <= grant_m1 ? m1_addr  : m0_addr;
        bus_we    <= grant_m1 ? m1_we    : m0_we;
        bus_wdata <= grant_m1 ? m1_wdata : m0_wdata;
      end
      if (capture) begin
        if (owner) begin
          m1_rdata <= bus_rdata;
        end else begin
          m0_rdata <= bus_rdata;
        end
      end
    end
  end

  // Strobes are pure state decodes, so a reset abandons any transfer at once.
  assign bus_sel = (state == ISSUE);
  assign busy    = (state != IDLE);
  assign m0_ack  = (state == DONE) && !owner;
  assign m1_ack  = (state == DONE) && owner;

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter
//   Bench for xbus_arbiter. One instance with RD_LAT=1 carries the table of
//   arbitration vectors and the reset-abandon sequence; a second instance with
//   RD_LAT=4 checks long read latency. A bus model returns valid read data
//   only in the cycle RD_LAT after bus_sel, so early or late capture shows up.
module tb_xbus_arbiter;

  logic        clk;
  logic        rst;
  int          cyc;
  int          checks;
  int          failures;

  // RD_LAT=1 instance signals
  logic        m0_req, m0_lock, m0_we, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        bus_sel, bus_we, owner, busy;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = 32'h0;

  // RD_LAT=4 instance signals
  logic        q_m0_req, q_m0_lock, q_m0_we, q_m0_ack;
  logic [31:0] q_m0_addr, q_m0_wdata, q_m0_rdata;
  logic        q_m1_req, q_m1_we, q_m1_ack;
  logic [31:0] q_m1_addr, q_m1_wdata, q_m1_rdata;
  logic        q_bus_sel, q_bus_we, q_owner, q_busy;
  logic [31:0] q_bus_addr, q_bus_wdata;
  logic [31:0] q_bus_rdata = 32'h0;

  xbus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .owner(owner), .busy(busy)
  );

  xbus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .m0_req(q_m0_req), .m0_lock(q_m0_lock), .m0_addr(q_m0_addr), .m0_we(q_m0_we),
    .m0_wdata(q_m0_wdata), .m0_ack(q_m0_ack), .m0_rdata(q_m0_rdata),
    .m1_req(q_m1_req), .m1_addr(q_m1_addr), .m1_we(q_m1_we),
    .m1_wdata(q_m1_wdata), .m1_ack(q_m1_ack), .m1_rdata(q_m1_rdata),
    .bus_sel(q_bus_sel), .bus_addr(q_bus_addr), .bus_we(q_bus_we),
    .bus_wdata(q_bus_wdata), .bus_rdata(q_bus_rdata),
    .owner(q_owner), .busy(q_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read data the decoder would return for a given address.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h20) return 32'h12345678;
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // Bus models: valid data only in the cycle RD_LAT after the sel cycle.
  int          sel_cyc = -100;
  logic [31:0] sel_addr = 32'h0;
  int          q_sel_cyc = -100;
  logic [31:0] q_sel_addr = 32'h0;

  always @(negedge clk) begin
    if (bus_sel === 1'b1) begin
      sel_cyc  = cyc;
      sel_addr = bus_addr;
    end
    if (q_bus_sel === 1'b1) begin
      q_sel_cyc  = cyc;
      q_sel_addr = q_bus_addr;
    end
  end

  always @(posedge clk) begin
    #2;
    bus_rdata   = (cyc == sel_cyc + 1)   ? rd_val(sel_addr)   : (32'hBAD00000 ^ 32'(cyc));
    q_bus_rdata = (cyc == q_sel_cyc + 4) ? rd_val(q_sel_addr) : (32'hBAD40000 ^ 32'(cyc));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: one expected transfer is pushed when a vector is driven and
  // checked against bus_sel and then popped at the ack.
  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          sel_cyc;
    int          ack_cyc;
  } sb_t;

  sb_t         sb[$];
  bit          front_sel_seen;
  logic        prev_sel = 1'b0;
  logic [31:0] last_rd [2];

  always @(negedge clk) begin
    sb_t e;
    if (bus_sel === 1'b1) begin
      checkOutput("sel_adjacent", 32'(prev_sel), 32'h0);
      if (sb.size() == 0 || front_sel_seen) begin
        checkOutput("unexpected_sel", 32'(bus_sel), 32'h0);
      end else begin
        checkOutput("sel_owner", 32'(owner), 32'(sb[0].who));
        checkOutput("sel_we", 32'(bus_we), 32'(sb[0].we));
        checkOutput("sel_addr", bus_addr, sb[0].addr);
        if (sb[0].we) checkOutput("sel_wdata", bus_wdata, sb[0].wdata);
        checkOutput("sel_cycle", 32'(cyc), 32'(sb[0].sel_cyc));
        front_sel_seen = 1'b1;
      end
    end
    prev_sel = (bus_sel === 1'b1);
    if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", 32'({m1_ack, m0_ack}), 32'h0);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_who", 32'({m1_ack, m0_ack}), e.who ? 32'h2 : 32'h1);
        checkOutput("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        checkOutput(e.who ? "m1_rdata" : "m0_rdata", e.who ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end

  typedef struct {
    logic        req0;
    logic        lock0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        exp_m1;
  } vec_t;

  // Drive one vector in an IDLE cycle, predict the transfer, wait for the ack,
  // and return at the start of the following IDLE cycle.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    bit  got;
    m0_req = v.req0; m0_lock = v.lock0; m0_we = v.we0;
    m0_addr = v.addr0; m0_wdata = v.wdata0;
    m1_req = v.req1; m1_we = v.we1; m1_addr = v.addr1; m1_wdata = v.wdata1;
    e.who   = v.exp_m1;
    e.we    = v.exp_m1 ? v.we1 : v.we0;
    e.addr  = v.exp_m1 ? v.addr1 : v.addr0;
    e.wdata = v.exp_m1 ? v.wdata1 : v.wdata0;
    if (e.we) begin
      e.rdata = last_rd[e.who];
    end else begin
      e.rdata = rd_val(e.addr);
      last_rd[e.who] = e.rdata;
    end
    e.sel_cyc = cyc + 1;
    e.ack_cyc = cyc + (e.we ? 2 : 3);
    front_sel_seen = 1'b0;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout actual=no_ack_in_30_cycles required=ack");
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [12];

  initial begin
    int g;
    int q_sel_count, q_sel_at, q_ack_at, q_m1_acks;
    logic [31:0] q_rd;
    sb_t e;

    // Single transfers, round-robin with both held, lock hold and release.
    vecs[0]  = '{1, 0, 1, 32'h010, 32'hDEADBEEF, 0, 0, 32'h000, 32'h0,        0};
    vecs[1]  = '{0, 0, 0, 32'h000, 32'h0,        1, 0, 32'h020, 32'h0,        1};
    vecs[2]  = '{1, 0, 1, 32'h100, 32'h11111111, 1, 0, 32'h104, 32'h0,        0};
    vecs[3]  = '{1, 0, 0, 32'h108, 32'h0,        1, 0, 32'h104, 32'h0,        1};
    vecs[4]  = '{1, 0, 0, 32'h108, 32'h0,        1, 1, 32'h10C, 32'h22222222, 0};
    vecs[5]  = '{1, 0, 0, 32'h200, 32'h0,        1, 1, 32'h10C, 32'h22222222, 1};
    vecs[6]  = '{1, 1, 0, 32'h200, 32'h0,        1, 1, 32'h300, 32'h33333333, 0};
    vecs[7]  = '{1, 1, 1, 32'h204, 32'h44444444, 1, 1, 32'h300, 32'h33333333, 0};
    vecs[8]  = '{1, 1, 0, 32'h208, 32'h0,        1, 1, 32'h300, 32'h33333333, 0};
    vecs[9]  = '{1, 0, 1, 32'h20C, 32'h55555555, 1, 1, 32'h300, 32'h33333333, 1};
    vecs[10] = '{0, 1, 0, 32'h000, 32'h0,        1, 0, 32'h304, 32'h0,        1};
    vecs[11] = '{1, 0, 1, 32'h20C, 32'h55555555, 0, 0, 32'h000, 32'h0,        0};

    checks = 0;
    failures = 0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    front_sel_seen = 1'b0;
    rst = 1'b1;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    q_m0_req = 0; q_m0_lock = 0; q_m0_we = 0; q_m0_addr = 0; q_m0_wdata = 0;
    q_m1_req = 0; q_m1_we = 0; q_m1_addr = 0; q_m1_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_bus_sel", 32'(bus_sel), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h1);
    checkOutput("rst_acks", 32'({m1_ack, m0_ack}), 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
    checkOutput("rst_q_owner", 32'(q_owner), 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    m0_req = 0; m0_lock = 0; m1_req = 0;

    // Reset during the WAIT cycle of an m1 read abandons it without an ack.
    repeat (2) @(posedge clk);
    #1;
    g = cyc;
    m1_req = 1; m1_we = 0; m1_addr = 32'h50;
    e.who = 1; e.we = 0; e.addr = 32'h50; e.wdata = 32'h0;
    e.rdata = rd_val(32'h50); e.sel_cyc = g + 1; e.ack_cyc = g + 3;
    front_sel_seen = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    m1_req = 0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_bus_sel", 32'(bus_sel), 32'h0);
    checkOutput("abort_owner", 32'(owner), 32'h1);
    checkOutput("abort_m1_ack", 32'(m1_ack), 32'h0);
    checkOutput("abort_m1_rdata", m1_rdata, 32'h0);
    repeat (6) @(negedge clk);
    checkOutput("abort_idle_after", 32'(busy), 32'h0);

    // RD_LAT=4: m0 read, sel in +1, ack in +6, data from 4 cycles after sel.
    @(posedge clk);
    #1;
    g = cyc;
    q_m0_req = 1; q_m0_we = 0; q_m0_addr = 32'h40;
    q_sel_count = 0; q_sel_at = -1; q_ack_at = -1; q_m1_acks = 0; q_rd = 32'h0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (q_bus_sel === 1'b1) begin
        q_sel_count++;
        q_sel_at = cyc;
      end
      if (q_m1_ack === 1'b1) q_m1_acks++;
      if (q_m0_ack === 1'b1 && q_ack_at < 0) begin
        q_ack_at = cyc;
        q_rd = q_m0_rdata;
        q_m0_req = 0;
      end
    end
    checkOutput("lat4_sel_count", 32'(q_sel_count), 32'h1);
    checkOutput("lat4_sel_cycle", 32'(q_sel_at), 32'(g + 1));
    checkOutput("lat4_ack_cycle", 32'(q_ack_at), 32'(g + 6));
    checkOutput("lat4_rdata", q_rd, rd_val(32'h40));
    checkOutput("lat4_m1_acks", 32'(q_m1_acks), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
